// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL field
// positions and the bus-side FSM state type.
package timer_pkg;

  localparam logic [31:0] OFF_MTIME_LO = 32'h00;
  localparam logic [31:0] OFF_MTIME_HI = 32'h04;
  localparam logic [31:0] OFF_CMP_LO   = 32'h08;
  localparam logic [31:0] OFF_CMP_HI   = 32'h0C;
  localparam logic [31:0] OFF_CTRL     = 32'h10;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;

  typedef enum logic {
    IDLE,
    RESP
  } tmr_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable divider that paces mtime.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   en        - count enable; when low the count is frozen
//   div       - terminal count; a tick fires every div+1 enabled cycles
//   clr       - synchronous clear of the count (CTRL write)
//   tick      - one-cycle pulse when the count reaches div
module timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = en && (count == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime advanced by a prescaler,
// 64-bit mtimecmp, and a registered interrupt level to the CSR unit.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   req_valid/req_ready    - request handshake (single outstanding)
//   req_write, req_addr,
//   req_wdata              - access type, byte offset, write data
//   rsp_valid/rsp_ready    - response handshake
//   rsp_rdata, rsp_err     - read data (0 for writes/errors), unmapped flag
//   tm_interrupt           - EN && (mtime >= mtimecmp), registered
module machine_timer
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PRESC_W = 8,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              tm_interrupt
);

  tmr_state_t         state, state_next;
  logic [63:0]        mtime, mtimecmp;
  logic [31:0]        hi_shadow;
  logic               en;
  logic [PRESC_W-1:0] div;
  logic               tick;

  logic        accept;
  logic [31:0] off;
  logic        sel_lo, sel_hi, sel_clo, sel_chi, sel_ctrl, addr_ok;
  logic [31:0] rd_data;
  logic        addr_unused;

  assign accept      = (state == IDLE) && req_valid;
  assign off         = 32'({req_addr[ADDR_W-1:2], 2'b00});
  assign addr_unused = ^req_addr[1:0];

  always_comb begin
    sel_lo   = (off == OFF_MTIME_LO);
    sel_hi   = (off == OFF_MTIME_HI);
    sel_clo  = (off == OFF_CMP_LO);
    sel_chi  = (off == OFF_CMP_HI);
    sel_ctrl = (off == OFF_CTRL);
    addr_ok  = sel_lo | sel_hi | sel_clo | sel_chi | sel_ctrl;
  end

  always_comb begin
    rd_data = '0;
    if (sel_lo)   rd_data = mtime[31:0];
    if (sel_hi)   rd_data = hi_shadow;
    if (sel_clo)  rd_data = mtimecmp[31:0];
    if (sel_chi)  rd_data = mtimecmp[63:32];
    if (sel_ctrl) rd_data = (32'(div) << CTRL_DIV_LSB) | {31'b0, en};
  end

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .div (div),
    .clr (accept && req_write && sel_ctrl),
    .tick(tick)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // A software write to either mtime half takes priority over a tick in
  // the same cycle; that tick is simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (accept && req_write && sel_lo) begin
      mtime <= {mtime[63:32], req_wdata};
    end else if (accept && req_write && sel_hi) begin
      mtime <= {req_wdata, mtime[31:0]};
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp  <= CMP_RST;
      en        <= 1'b0;
      div       <= '0;
      hi_shadow <= '0;
    end else if (accept) begin
      if (req_write) begin
        if (sel_clo)  mtimecmp[31:0]  <= req_wdata;
        if (sel_chi)  mtimecmp[63:32] <= req_wdata;
        if (sel_ctrl) begin
          en  <= req_wdata[CTRL_EN];
          div <= req_wdata[CTRL_DIV_LSB +: PRESC_W];
        end
      end else if (sel_lo) begin
        // Capture the upper half alongside the LO read so a following HI
        // read sees a coherent 64-bit value.
        hi_shadow <= mtime[63:32];
      end
    end
  end

  // Response payload only loads on accept, so it stays stable in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (req_write || !addr_ok) ? '0 : rd_data;
      rsp_err   <= !addr_ok;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tm_interrupt <= 1'b0;
    else      tm_interrupt <= en && (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_machine_timer.sv
module tb_machine_timer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tm_interrupt;

  int n_vec = 0;
  int n_bad = 0;

  machine_timer #(
    .ADDR_W (5),
    .PRESC_W(8),
    .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .tm_interrupt(tm_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic start(input logic w, input logic [4:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsp_valid_after_accept", 64'(rsp_valid), 64'd1);
  endtask

  // Samples the response, completes the handshake, returns at a negedge.
  task automatic finish(output logic [31:0] rd, output logic e);
    rd = rsp_rdata;
    e  = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(input string name, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    start(w, a, d);
    finish(rd, e);
    chk({name, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({name, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic stall_read(input string name, input logic [4:0] a,
                            input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    start(1'b0, a, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("%s_stall%0d_valid", name, i), 64'(rsp_valid), 64'd1);
      chk($sformatf("%s_stall%0d_err", name, i), 64'(rsp_err), 64'(exp_err));
      chk($sformatf("%s_stall%0d_rdata", name, i), 64'(rsp_rdata), 64'(exp_rd));
      chk($sformatf("%s_stall%0d_req_ready", name, i), 64'(req_ready), 64'd0);
    end
    finish(rd, e);
    chk({name, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({name, "_err"}, 64'(e), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Register-level vectors, timer disabled throughout.
    tbl.push_back('{1'b0, 5'h0C, 32'h0,         32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 5'h08, 32'h0,         32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 5'h10, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h04, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h14, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 5'h1C, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b1, 5'h18, 32'hDEAD_BEEF, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 5'h08, 32'd10,        32'h0,         1'b0});
    tbl.push_back('{1'b1, 5'h0C, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h08, 32'h0,         32'd10,        1'b0});
    tbl.push_back('{1'b0, 5'h0B, 32'h0,         32'd10,        1'b0});
    tbl.push_back('{1'b0, 5'h0C, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 5'h00, 32'h1234_5678, 32'h0,         1'b0});
    tbl.push_back('{1'b1, 5'h04, 32'h0000_00AB, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         32'h1234_5678, 1'b0});
    tbl.push_back('{1'b0, 5'h04, 32'h0,         32'h0000_00AB, 1'b0});
    tbl.push_back('{1'b1, 5'h10, 32'hFFFF_FFFE, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h10, 32'h0,         32'h0000_FF00, 1'b0});
    tbl.push_back('{1'b1, 5'h10, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h10, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 5'h00, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 5'h04, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 5'h04, 32'h0,         32'h0,         1'b0});

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_irq",       64'(tm_interrupt), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
           tbl[i].rdata, tbl[i].err);
      chk($sformatf("vec%0d_irq", i), 64'(tm_interrupt), 64'd0);
    end

    // Compare at mtime==10 with DIV=0: mtime==k after k edges past enable.
    xfer("en_div0", 1'b1, 5'h10, 32'h1, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    chk("irq_before_match", 64'(tm_interrupt), 64'd0);
    @(negedge clk);
    chk("irq_rise", 64'(tm_interrupt), 64'd1);
    start(1'b1, 5'h08, 32'd100);
    chk("irq_same_edge_as_cmp_write", 64'(tm_interrupt), 64'd1);
    finish(rd, e);
    chk("irq_drop", 64'(tm_interrupt), 64'd0);
    xfer("mtime_after_count", 1'b0, 5'h00, 32'h0, 32'd13, 1'b0);

    // DIV=3: one increment every 4 cycles, then freeze.
    xfer("dis", 1'b1, 5'h10, 32'h0, 32'h0, 1'b0);
    xfer("clr_lo", 1'b1, 5'h00, 32'h0, 32'h0, 1'b0);
    xfer("clr_hi", 1'b1, 5'h04, 32'h0, 32'h0, 1'b0);
    xfer("en_div3", 1'b1, 5'h10, 32'h0301, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer($sformatf("div3_rd%0d", i), 1'b0, 5'h00, 32'h0, 32'(i), 1'b0);
      if (i < 3) repeat (2) @(negedge clk);
    end
    xfer("dis2", 1'b1, 5'h10, 32'h0, 32'h0, 1'b0);
    xfer("frozen_a", 1'b0, 5'h00, 32'h0, 32'd4, 1'b0);
    repeat (20) @(negedge clk);
    xfer("frozen_b", 1'b0, 5'h00, 32'h0, 32'd4, 1'b0);
    chk("frozen_irq", 64'(tm_interrupt), 64'd0);

    // Carry into the upper half and hi_shadow coherence across a tick.
    xfer("wr_lo_max", 1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xfer("wr_hi_zero", 1'b1, 5'h04, 32'h0, 32'h0, 1'b0);
    xfer("en_div3b", 1'b1, 5'h10, 32'h0301, 32'h0, 1'b0);
    @(negedge clk);
    xfer("pre_tick_lo", 1'b0, 5'h00, 32'h0, 32'hFFFF_FFFF, 1'b0);
    xfer("shadow_hi",   1'b0, 5'h04, 32'h0, 32'h0, 1'b0);
    xfer("wrap_lo",     1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
    xfer("wrap_hi",     1'b0, 5'h04, 32'h0, 32'h1, 1'b0);

    // Software write coinciding with a tick: write wins, tick dropped.
    xfer("en_div0b", 1'b1, 5'h10, 32'h1, 32'h0, 1'b0);
    xfer("wr_lo_50", 1'b1, 5'h00, 32'h50, 32'h0, 1'b0);
    xfer("after_wr_lo", 1'b0, 5'h00, 32'h0, 32'h51, 1'b0);

    // Response held under back-pressure.
    stall_read("err_stall", 5'h14, 32'h0, 1'b1);
    stall_read("cmp_stall", 5'h08, 32'd100, 1'b0);

    // Asynchronous reset while a response is pending and the IRQ is high.
    chk("irq_high_before_rst", 64'(tm_interrupt), 64'd1);
    start(1'b0, 5'h0C, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd1);
    chk("async_rst_irq", 64'(tm_interrupt), 64'd0);
    chk("async_rst_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer("post_rst_lo",   1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
    xfer("post_rst_hi",   1'b0, 5'h04, 32'h0, 32'h0, 1'b0);
    xfer("post_rst_ctrl", 1'b0, 5'h10, 32'h0, 32'h0, 1'b0);
    xfer("post_rst_chi",  1'b0, 5'h0C, 32'h0, 32'hFFFF_FFFF, 1'b0);
    xfer("post_rst_clo",  1'b0, 5'h08, 32'h0, 32'hFFFF_FFFF, 1'b0);
    chk("post_rst_irq", 64'(tm_interrupt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped machine timer that produces the level `tm_interrupt` consumed by the CSR/interrupt-entry unit.
- Holds a 64-bit `mtime` counter, advanced by a programmable prescaler, and a 64-bit `mtimecmp` compare register.
- Software reaches it through a single-outstanding valid/ready request/response slave port driven by the bus bridge.
- `tm_interrupt` is registered and asserted while the timer is enabled and `mtime >= mtimecmp`.

Parameters:
- ADDR_W, 5, request byte-address width; register offsets 0x00..0x10.
- PRESC_W, 8, width of the prescaler divide field and counter.
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp`.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  slave can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte offset; bits [1:0] are ignored.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  unmapped address.
- tm_interrupt  out  1  timer interrupt level to the CSR unit.

Behaviour:
- Reset (rst=0, asynchronous):
  - `mtime`=0, `mtimecmp`=CMP_RST, CTRL=0 (disabled, divide 0), prescaler count=0, `hi_shadow`=0.
  - FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, tm_interrupt=0.
  - Reset mid-transaction drops the pending response; no partial register write survives.
- Register map:
  - 0x00 MTIME_LO: RW.
  - 0x04 MTIME_HI: read returns `hi_shadow`; write sets `mtime[63:32]`.
  - 0x08 MTIMECMP_LO: RW.
  - 0x0C MTIMECMP_HI: RW.
  - 0x10 CTRL: bit0 EN, bits[8+PRESC_W-1:8] DIV, other bits read 0.
  - Any other offset: rsp_err=1; a write has no effect.
- Atomic 64-bit read: reading MTIME_LO captures `mtime[63:32]` into `hi_shadow` in the same cycle. Software reads LO then HI.
- FSM:
  - States are IDLE and RESP.
  - IDLE: req_ready=1. On req_valid, the access is performed that cycle (write takes effect at that clock edge; read data is sampled), then go to RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_ready, return to IDLE.
  - Request-to-response latency is 1 cycle. Maximum throughput is 1 transaction per 2 cycles.
- Prescaler:
  - While EN=1 the count increments each cycle.
  - When count == DIV, a tick fires and the count returns to 0. DIV=0 gives a tick every cycle; DIV=N gives a tick every N+1 cycles.
  - EN=0 freezes the count and `mtime`. Writing CTRL clears the count.
- `mtime` advances by 1 on each tick and wraps 2^64-1 -> 0 with no flag.
- Simultaneous software write and tick: the write wins. The written half takes `wdata`, the other half keeps its current value, and that tick is lost.
- Compare: `tm_interrupt` <= EN && (`mtime` >= `mtimecmp`), unsigned 64-bit, registered, so it lags a state change by 1 cycle.
  - Clearing the interrupt is done by raising `mtimecmp` or disabling the timer; there is no sticky bit.
  - Writing `mtimecmp` halves one at a time may glitch the interrupt. Software sets HI to all ones first; this is documented, not prevented.
- `tm_interrupt` is unaffected by bus stalls and is held level until the condition clears.

Decomposition:
- Package `timer_pkg` holds:
  - offset localparams: OFF_MTIME_LO, OFF_MTIME_HI, OFF_CMP_LO, OFF_CMP_HI, OFF_CTRL;
  - CTRL bit positions: CTRL_EN, CTRL_DIV_LSB;
  - the FSM enum `tmr_state_t` {IDLE, RESP}.
- Sub-module `timer_prescaler` (inputs: en, div, clr; output: tick) contains the divide counter.
- Register file, FSM and compare logic stay in `machine_timer`.

Test Plan:
- Reset, then read MTIMECMP_HI -> rsp_rdata=32'hFFFF_FFFF, rsp_err=0, tm_interrupt=0; read CTRL -> 0.
- Write CMP_LO=10, CMP_HI=0, then CTRL=1 (EN, DIV=0) -> `mtime` counts 1/cycle; tm_interrupt rises 1 cycle after `mtime` reaches 10; writing CMP_LO=100 drops it 1 cycle later.
- Write CTRL=0x0301 (DIV=3) -> `mtime` increments exactly once every 4 cycles; write CTRL=0 -> `mtime` frozen across 20 cycles.
- Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, then run -> after 1 tick, read LO=0 and HI=1, with HI returned from `hi_shadow` even when a tick lands between the two reads.
- Read from 0x14 -> rsp_err=1, rsp_rdata=0. Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_err and rsp_rdata stable, req_ready=0 throughout.
- Assert rst low while in RESP with EN=1 and tm_interrupt=1 -> rsp_valid=0, tm_interrupt=0 and `mtime`=0 immediately, without waiting for clk.
